// File: rtl/usb_status_pkg.sv
// Shared constants and FSM state type for the USB CDC-ACM status transmitter.
// Also holds the fixed banner text lookup used when the banner feature is built.
package usb_status_pkg;

  localparam int LINE_LEN   = 13;
  localparam int BANNER_LEN = 13;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_0  = 8'h30;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    DONE,
    BANNER
  } state_t;

  function automatic logic [7:0] banner_char(input logic [3:0] i);
    logic [7:0] c;
    c = 8'h00;
    unique case (i)
      4'd0:    c = "h";
      4'd1:    c = "e";
      4'd2:    c = "l";
      4'd3:    c = "l";
      4'd4:    c = "o";
      4'd5:    c = " ";
      4'd6:    c = "w";
      4'd7:    c = "o";
      4'd8:    c = "r";
      4'd9:    c = "l";
      4'd10:   c = "d";
      4'd11:   c = CH_LF;
      4'd12:   c = CH_CR;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit value to uppercase hexadecimal ASCII character.
// Used for the two digits of the sequence number field.
module nibble_to_ascii
  import usb_status_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // '0'..'9' then 'A'..'F' ('A' - 10 = 8'h37)
  always_comb begin
    if (nibble < 4'd10) ascii = CH_0 + {4'h0, nibble};
    else                ascii = 8'h37 + {4'h0, nibble};
  end

endmodule

// File: rtl/usb_status_tx.sv
// Periodic / on-demand "RGB=<r><g><b> #<HH>\r\n" sender onto the usb_uart byte stream.
// Build option USB_STATUS_TX_BANNER_EN sends "hello world\n\r" once after reset.
module usb_status_tx
  import usb_status_pkg::*;
#(
  parameter int PERIOD_CYCLES = 48000000,
  parameter int CNT_W         = 26
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       red,
  input  logic       green,
  input  logic       blue,
  input  logic       trigger,
  output logic [7:0] uart_in_data,
  output logic       uart_in_valid,
  input  logic       uart_in_ready,
  output logic       busy
);

  state_t state, state_n;

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             req;
  logic             pending;
  logic             go;
  logic [7:0]       seq;
  logic [7:0]       seq_q;
  logic [2:0]       rgb_q;
  logic [3:0]       idx;
  logic             hs;
  logic             last;
  logic [7:0]       hex_hi;
  logic [7:0]       hex_lo;
  logic [7:0]       line_char;
`ifdef USB_STATUS_TX_BANNER_EN
  logic             banner_done;
`endif

  assign tick = (cnt == CNT_W'(PERIOD_CYCLES - 1));
  assign req  = tick | trigger;
  assign hs   = uart_in_valid & uart_in_ready;
  assign last = (idx == 4'(LINE_LEN - 1));
  assign go   = (state == IDLE) && (state_n == LOAD);
  assign busy = (state != IDLE);

  nibble_to_ascii u_hex_hi (
    .nibble (seq_q[7:4]),
    .ascii  (hex_hi)
  );

  nibble_to_ascii u_hex_lo (
    .nibble (seq_q[3:0]),
    .ascii  (hex_lo)
  );

  // Free-running period counter, wraps on the tick cycle
  always_ff @(posedge clk_48mhz) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // Request latch: coalesces any number of ticks/triggers into one line
  always_ff @(posedge clk_48mhz) begin
    if (reset)    pending <= 1'b0;
    else if (go)  pending <= 1'b0;
    else if (req) pending <= 1'b1;
  end

  // State register
  always_ff @(posedge clk_48mhz) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
`ifdef USB_STATUS_TX_BANNER_EN
        if (!banner_done)         state_n = BANNER;
        else if (pending || req)  state_n = LOAD;
`else
        if (pending || req)       state_n = LOAD;
`endif
      end
      LOAD: state_n = SEND;
      SEND: if (hs && last) state_n = DONE;
      DONE: state_n = IDLE;
`ifdef USB_STATUS_TX_BANNER_EN
      BANNER: if (hs && idx == 4'(BANNER_LEN - 1)) state_n = IDLE;
`else
      BANNER: state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end

  // Line snapshot, character index and sequence number
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      idx   <= '0;
      seq   <= '0;
      seq_q <= '0;
      rgb_q <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          rgb_q <= {red, green, blue};
          seq_q <= seq;
          idx   <= '0;
        end
        SEND, BANNER: begin
          if (hs) idx <= last ? 4'd0 : idx + 4'd1;
        end
        DONE: seq <= seq + 8'd1;
        default: idx <= '0;
      endcase
    end
  end

`ifdef USB_STATUS_TX_BANNER_EN
  // Banner goes out once per reset
  always_ff @(posedge clk_48mhz) begin
    if (reset) banner_done <= 1'b0;
    else if (state == BANNER && state_n == IDLE) banner_done <= 1'b1;
  end
`endif

  // Status line character map
  always_comb begin
    line_char = 8'h00;
    unique case (idx)
      4'd0:    line_char = "R";
      4'd1:    line_char = "G";
      4'd2:    line_char = "B";
      4'd3:    line_char = "=";
      4'd4:    line_char = CH_0 + {7'd0, rgb_q[2]};
      4'd5:    line_char = CH_0 + {7'd0, rgb_q[1]};
      4'd6:    line_char = CH_0 + {7'd0, rgb_q[0]};
      4'd7:    line_char = " ";
      4'd8:    line_char = "#";
      4'd9:    line_char = hex_hi;
      4'd10:   line_char = hex_lo;
      4'd11:   line_char = CH_CR;
      4'd12:   line_char = CH_LF;
      default: line_char = 8'h00;
    endcase
  end

  // Byte stream outputs, decoded from state so valid never glitches mid-line
  always_comb begin
    uart_in_valid = 1'b0;
    uart_in_data  = 8'h00;
    if (state == SEND) begin
      uart_in_valid = 1'b1;
      uart_in_data  = line_char;
    end
`ifdef USB_STATUS_TX_BANNER_EN
    if (state == BANNER) begin
      uart_in_valid = 1'b1;
      uart_in_data  = banner_char(idx);
    end
`endif
  end

endmodule

// File: tb/tb_usb_status_tx.sv
// Self-checking bench for usb_status_tx: byte scoreboard plus a periodic instance.
// Banner expectations follow USB_STATUS_TX_BANNER_EN.
module tb_usb_status_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       red, green, blue, trigger, ready;
  logic [7:0] data;
  logic       valid, busy;

  logic       rst_p;
  logic       p_r = 1'b0, p_g = 1'b1, p_b = 1'b1;
  logic       p_trig = 1'b0, p_ready = 1'b1;
  logic [7:0] p_data;
  logic       p_valid, p_busy;

  always #5 clk = ~clk;

  usb_status_tx dut (
    .clk_48mhz     (clk),
    .reset         (reset),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .trigger       (trigger),
    .uart_in_data  (data),
    .uart_in_valid (valid),
    .uart_in_ready (ready),
    .busy          (busy)
  );

  usb_status_tx #(.PERIOD_CYCLES(100), .CNT_W(7)) dut_p (
    .clk_48mhz     (clk),
    .reset         (rst_p),
    .red           (p_r),
    .green         (p_g),
    .blue          (p_b),
    .trigger       (p_trig),
    .uart_in_data  (p_data),
    .uart_in_valid (p_valid),
    .uart_in_ready (p_ready),
    .busy          (p_busy)
  );

  typedef struct {
    logic         r, g, b;
    logic [103:0] line;
  } vec_t;

  vec_t       tbl[4];
  logic [7:0] exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         hs_cnt = 0;
  int         cyc = 0;
  logic [7:0] seq_exp;
  logic [103:0] banner;

  logic [7:0] p_buf[3][13];
  int         p_start[3];
  int         p_pos = 0;
  int         p_lines = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hexc(logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  function automatic logic [103:0] make_line(logic r, logic g, logic b,
                                             logic [7:0] s);
    return {"RGB=", 8'h30 | {7'd0, r}, 8'h30 | {7'd0, g},
            8'h30 | {7'd0, b}, " #", hexc(s[7:4]), hexc(s[3:0]),
            8'h0D, 8'h0A};
  endfunction

  task automatic push_line(logic [103:0] l);
    for (int i = 0; i < 13; i++) exp_q.push_back(l[8*(12-i) +: 8]);
  endtask

  // Scoreboard: every accepted byte must be the next expected one
  always @(negedge clk) begin
    if (valid === 1'b1 && ready === 1'b1) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected byte: got %h expected none", data);
      end else begin
        check("byte", {24'h0, data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  always @(posedge clk) cyc++;

  // Collect the first three status lines of the periodic instance
  always @(negedge clk) begin
    if (rst_p === 1'b0 && p_valid === 1'b1 && p_lines < 3) begin
      if (!(p_pos == 0 && p_data != 8'h52)) begin
        if (p_pos == 0) p_start[p_lines] = cyc;
        p_buf[p_lines][p_pos] = p_data;
        p_pos++;
        if (p_pos == 13) begin
          p_pos = 0;
          p_lines++;
        end
      end
    end
  end

  task automatic pulse();
    @(posedge clk); #1 trigger = 1'b1;
    @(posedge clk); #1 trigger = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 4000; n++) begin
      if (exp_q.size() == 0 && busy === 1'b0) break;
      @(posedge clk); #1;
    end
    vectors++;
    if (n == 4000) begin
      miscompares++;
      $display("FAIL drain: got queue=%0d busy=%b expected 0/0",
               exp_q.size(), busy);
    end
  endtask

  task automatic wait_hs(int target);
    int n;
    for (n = 0; n < 200; n++) begin
      if (hs_cnt >= target) break;
      @(posedge clk); #1;
    end
    check("wait_hs", hs_cnt, target);
  endtask

  task automatic release_reset();
    reset = 1'b0;
`ifdef USB_STATUS_TX_BANNER_EN
    push_line(banner);
`endif
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    banner = {"hello world", 8'h0A, 8'h0D};
    tbl[0] = '{1'b1, 1'b0, 1'b1, {"RGB=101 #00", 8'h0D, 8'h0A}};
    tbl[1] = '{1'b0, 1'b0, 1'b0, {"RGB=000 #01", 8'h0D, 8'h0A}};
    tbl[2] = '{1'b1, 1'b1, 1'b1, {"RGB=111 #02", 8'h0D, 8'h0A}};
    tbl[3] = '{1'b0, 1'b1, 1'b0, {"RGB=010 #03", 8'h0D, 8'h0A}};

    reset = 1'b1; rst_p = 1'b1; trigger = 1'b0; ready = 1'b1;
    red = 1'b0; green = 1'b0; blue = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", data, 0);
    rst_p = 1'b0;
    release_reset();

`ifdef USB_STATUS_TX_BANNER_EN
    repeat (3) @(posedge clk);
    #1;
    check("banner_busy", busy, 1);
    red = 1'b1; green = 1'b1; blue = 1'b0;
    push_line(make_line(1'b1, 1'b1, 1'b0, 8'h00));
    pulse();
    drain();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    release_reset();
    drain();
`else
    drain();
`endif

    // Table-driven lines, seq 00..03
    for (int i = 0; i < 4; i++) begin
      red = tbl[i].r; green = tbl[i].g; blue = tbl[i].b;
      push_line(tbl[i].line);
      if (i == 0) begin
        @(posedge clk); #1 trigger = 1'b1;
        @(posedge clk); #1 trigger = 1'b0;
        check("lat_load_busy", busy, 1);
        check("lat_load_valid", valid, 0);
        @(posedge clk); #1;
        check("lat_first_valid", valid, 1);
        check("lat_first_data", data, 8'h52);
      end else begin
        pulse();
      end
      drain();
      check("busy_after_line", busy, 0);
    end
    seq_exp = 8'h04;

    // Back-pressure at index 4, LEDs change mid-line
    begin
      int base;
      red = 1'b1; green = 1'b0; blue = 1'b1;
      push_line(make_line(1'b1, 1'b0, 1'b1, seq_exp));
      base = hs_cnt;
      pulse();
      wait_hs(base + 4);
      ready = 1'b0;
      red = 1'b0; green = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check("stall_valid", valid, 1);
        check("stall_data", data, 8'h31);
      end
      @(posedge clk); #1 ready = 1'b1;
      drain();
      seq_exp++;
    end

    // Three triggers during one line coalesce into one follow-up
    push_line(make_line(red, green, blue, seq_exp));
    push_line(make_line(red, green, blue, seq_exp + 8'd1));
    pulse();
    for (int k = 0; k < 3; k++) begin
      repeat (2) @(posedge clk);
      #1 trigger = 1'b1;
      @(posedge clk); #1 trigger = 1'b0;
    end
    drain();
    repeat (60) @(posedge clk);
    #1;
    check("no_third_line", busy, 0);
    seq_exp = seq_exp + 8'd2;

    // Run seq up through FF, then the wrap line must read #00
    do begin
      push_line(make_line(red, green, blue, seq_exp));
      pulse();
      drain();
      seq_exp++;
    end while (seq_exp != 8'h00);
    red = 1'b0; green = 1'b0; blue = 1'b0;
    push_line({"RGB=000 #00", 8'h0D, 8'h0A});
    pulse();
    drain();

    // Reset at index 7 abandons the line without advancing seq
    begin
      int base;
      push_line(make_line(1'b0, 1'b0, 1'b0, 8'h01));
      base = hs_cnt;
      pulse();
      wait_hs(base + 7);
      reset = 1'b1;
      @(posedge clk); #1;
      check("midrst_valid", valid, 0);
      check("midrst_busy", busy, 0);
      exp_q.delete();
      release_reset();
      drain();
      red = 1'b0; green = 1'b0; blue = 1'b1;
      push_line({"RGB=001 #00", 8'h0D, 8'h0A});
      pulse();
      drain();
    end

    // Periodic instance: 100-cycle spacing, seq 00,01,02
    check("periodic_lines", p_lines, 3);
    if (p_lines == 3) begin
      for (int k = 0; k < 3; k++) begin
        logic [103:0] l;
        l = make_line(1'b0, 1'b1, 1'b1, 8'(k));
        for (int i = 0; i < 13; i++)
          check("periodic_byte", p_buf[k][i], l[8*(12-i) +: 8]);
        if (k > 0)
          check("periodic_gap", p_start[k] - p_start[k-1], 100);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usb_status_tx.md
Name: usb_status_tx

Overview:
- Device→host transmitter for the USB CDC-ACM link.
- Sits beside the LED command receiver and drives the usb_uart "uart_in" byte stream (valid/ready).
- Sends a fixed-format ASCII status line, `RGB=<r><g><b> #<HH>\r\n`:
  - the three chars `<r><g><b>` are the LED state bits as '0'/'1';
  - `HH` is an 8-bit message sequence number in uppercase hex.
- Sends the line periodically and also on demand.

Parameters:
- PERIOD_CYCLES, 48000000, clk_48mhz cycles between periodic status lines (1 s at 48 MHz); must be ≥ 2.
- CNT_W, 26, width of the period counter; must satisfy 2^CNT_W > PERIOD_CYCLES.

Ports:
- clk_48mhz  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- red  input  1  red LED state, sampled at line start.
- green  input  1  green LED state, sampled at line start.
- blue  input  1  blue LED state, sampled at line start.
- trigger  input  1  one-cycle pulse requesting an immediate status line.
- uart_in_data  output  8  byte to usb_uart.
- uart_in_valid  output  1  byte valid.
- uart_in_ready  input  1  usb_uart accepts the byte when valid & ready are high on the same edge.
- busy  output  1  high while a line is in progress (IDLE excluded).

Behaviour:
- Reset values: uart_in_valid=0, uart_in_data=8'h00, busy=0, seq=8'h00, period counter=0, pending=0, state=IDLE.
- Period counter:
  - Free-running; increments every cycle.
  - When it equals PERIOD_CYCLES-1 it wraps to 0 and raises a one-cycle tick.
  - Runs regardless of state.
- pending flag:
  - Set by tick or trigger.
  - Cleared on the cycle the FSM leaves IDLE for LOAD.
  - Multiple requests while busy coalesce into one follow-up line.
- FSM states:
  - IDLE: if pending (or tick/trigger this cycle) → LOAD.
  - LOAD, one cycle:
    - snapshot {red,green,blue} and seq into line registers;
    - char index := 0;
    - → SEND.
  - SEND:
    - uart_in_valid=1; uart_in_data = char[index].
    - On handshake with index<12: index+1, stay in SEND.
    - On handshake with index=12: → DONE.
  - DONE, one cycle:
    - uart_in_valid=0;
    - seq := seq+1 (mod 256, 8'hFF wraps to 8'h00);
    - → IDLE.
- Character map, index 0..12:
  - 'R' 'G' 'B' '=' r g b ' ' '#' hex(seq[7:4]) hex(seq[3:0]) 8'h0D 8'h0A.
  - Each LED bit maps as 0→8'h30, 1→8'h31.
  - hex: 0-9→8'h30+n; A-F→8'h41+(n-10).
- Handshake rules:
  - uart_in_valid is held high continuously within SEND. It never drops between bytes of one line, except that DONE is one cycle low.
  - uart_in_data is stable while valid is high and ready is low.
  - Data advances only on the handshake edge.
- Latency:
  - First byte is valid 2 cycles after trigger is sampled in IDLE.
  - With ready tied high, a line occupies 13 consecutive valid cycles. The next line starts no earlier than 3 cycles after the last byte.
- LED inputs changing mid-line do not affect the line in flight (snapshot).
- reset asserted mid-line:
  - next edge forces all reset values;
  - the partial line is abandoned (host sees a truncated line);
  - seq is not incremented.
- busy = (state != IDLE).

Optional Feature:
- Macro: USB_STATUS_TX_BANNER_EN.
- Defined:
  - After reset, the FSM first enters BANNER and sends the 13-byte `hello world\n\r` (8'h68…8'h0A,8'h0D) using the same SEND handshake rules.
  - It then goes to IDLE.
  - Ticks or triggers during the banner set pending.
  - The banner does not increment seq.
  - busy is high during the banner.
- Undefined: no BANNER state; the FSM comes out of reset in IDLE.

Decomposition:
- Package usb_status_pkg holds:
  - LINE_LEN=13, BANNER_LEN=13;
  - ASCII constants CH_CR=8'h0D, CH_LF=8'h0A, CH_0=8'h30;
  - the FSM state enum {IDLE, LOAD, SEND, DONE, BANNER}.
- One sub-module, nibble_to_ascii: combinational 4-bit → uppercase hex ASCII, instantiated twice.

Test Plan:
- Trigger pulse, ready=1, red=1, green=0, blue=1, seq=0:
  - 13 consecutive handshakes carry "RGB=101 #00\r\n";
  - busy then falls;
  - seq becomes 8'h01.
- Ready low for 5 cycles at index 4:
  - uart_in_data holds 8'h31 and valid stays 1 throughout;
  - the line completes intact after ready rises.
- Three triggers during one line:
  - exactly one follow-up line, "…#01\r\n", follows;
  - no third line is sent.
- PERIOD_CYCLES=100, ready=1, no trigger: lines start every 100 cycles; the seq field counts 00,01,02.
- Force 256 lines: the line after #FF reads "#00".
- Reset asserted at index 7:
  - next cycle valid=0, busy=0;
  - the next trigger sends "…#00" (seq not advanced).
- With USB_STATUS_TX_BANNER_EN, after reset, ready=1:
  - the first 13 bytes are "hello world\n\r";
  - a trigger given during the banner yields "RGB=… #00" immediately after it.
